wb2csr: RTL

Wishbone-to-CSR bus bridge: the single initiator on the SoC CSR bus, driving address, write strobe and write data to every CSR peripheral and collecting their registered read data. It sits between the Wishbone interconnect and all CSR peripherals. Peripherals output zero when not selected, so their read buses are OR-combined at the top level. Partial-width Wishbone writes are turned into a CSR read-modify-write, because CSR registers are 32-bit only.

---
 rtl/wb2csr_if.sv | 22 ++
 rtl/wb2csr.sv | 129 ++++++++++++
 2 files changed

// File: rtl/wb2csr_if.sv
// Wishbone classic slave-side bus bundle for the CSR bridge.
// Member names follow the bridge's view: _i flows into the bridge, _o flows out of it.
interface wb2csr_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb2csr.sv
// Wishbone-to-CSR bridge: sole CSR bus initiator, registered outputs, and
// read-modify-write for partial-width writes since CSR registers are 32-bit only.
module wb2csr #(
  parameter bit rmw_enable = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  wb2csr_if.slave     wb,
  output logic [14:0] csr_a,
  output logic        csr_we,
  output logic [31:0] csr_do,
  input  logic [31:0] csr_di
);

  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, ACK} state_t;

  state_t      state_q, state_d;
  logic [14:0] csr_a_q, csr_a_d;
  logic        csr_we_q, csr_we_d;
  logic [31:0] csr_do_q, csr_do_d;
  logic [31:0] dat_q, dat_d;
  logic        ack_q, ack_d;
  logic        rmw_q, rmw_d;
  logic [3:0]  sel_q, sel_d;

  logic req, sel_full, sel_part;
  logic unused_adr;

  function automatic logic [31:0] expand_sel(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  sel);
    logic [31:0] m;
    m = expand_sel(sel);
    return (old_v & ~m) | (new_v & m);
  endfunction

  assign req        = wb.wb_cyc_i & wb.wb_stb_i;
  assign sel_full   = (wb.wb_sel_i == 4'hF);
  assign sel_part   = (wb.wb_sel_i != 4'h0) && !sel_full;
  assign unused_adr = ^{wb.wb_adr_i[31:17], wb.wb_adr_i[1:0]};

  always_comb begin
    state_d  = state_q;
    csr_a_d  = csr_a_q;
    csr_we_d = 1'b0;
    csr_do_d = csr_do_q;
    dat_d    = dat_q;
    ack_d    = 1'b0;
    rmw_d    = rmw_q;
    sel_d    = sel_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          csr_a_d  = wb.wb_adr_i[16:2];
          csr_do_d = wb.wb_dat_i;
          sel_d    = wb.wb_sel_i;
          rmw_d    = wb.wb_we_i;
          if (wb.wb_we_i && sel_full) begin
            csr_we_d = 1'b1;
            state_d  = WR;
          end else if (!wb.wb_we_i || (sel_part && rmw_enable)) begin
            state_d  = RD1;
          end else begin
            // Null write: nothing reaches the CSR bus, acknowledge at once.
            ack_d    = 1'b1;
            state_d  = ACK;
          end
        end
      end
      WR: begin
        if (wb.wb_cyc_i) begin
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      RD1: state_d = RD2;
      RD2: begin
        if (!wb.wb_cyc_i) begin
          state_d = IDLE;
        end else if (rmw_q) begin
          csr_do_d = merge(csr_di, csr_do_q, sel_q);
          csr_we_d = 1'b1;
          state_d  = WR;
        end else begin
          dat_d   = csr_di;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      csr_a_q  <= '0;
      csr_we_q <= 1'b0;
      csr_do_q <= '0;
      dat_q    <= '0;
      ack_q    <= 1'b0;
      rmw_q    <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      csr_a_q  <= csr_a_d;
      csr_we_q <= csr_we_d;
      csr_do_q <= csr_do_d;
      dat_q    <= dat_d;
      ack_q    <= ack_d;
      rmw_q    <= rmw_d;
      sel_q    <= sel_d;
    end
  end

  assign csr_a       = csr_a_q;
  assign csr_we      = csr_we_q;
  assign csr_do      = csr_do_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_ack_o = ack_q;

endmodule
